// File: rtl/remap_alloc_ctrl.sv
// Row-remapping allocation sequencer: loads faulty-column masks, then pairs
// each weight row with the lowest compatible unmatched faulty row.
module remap_alloc_ctrl #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     rd_en,
    output logic                     rd_sel,
    output logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [SYSTOLIC_SIZE-1:0] rd_data,
    output logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask,
    output logic                     table_init,
    output logic                     match_success,
    output logic                     match_failed,
    output logic                     all_faulty_matched,
    output logic [ADDR_WIDTH-1:0]    faulty_addr,
    output logic [ADDR_WIDTH-1:0]    current_row_addr,
    input  logic                     allocation_failed_in,
    output logic                     busy,
    output logic                     done,
    output logic                     alloc_fail,
    output logic [ADDR_WIDTH:0]      fail_count
);

    localparam int N = SYSTOLIC_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH:0]   FC_MAX = (ADDR_WIDTH + 1)'(N);

    typedef enum logic [2:0] {
        IDLE, LOAD, LOAD_LAST, ROW_RD, ROW_EVAL, ISSUE, CHECK, DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   idx, idx_nxt;
    logic [N-1:0][N-1:0]     fmask;
    logic [N-1:0]            matched;
    logic [N-1:0]            frm_nxt;
    logic [N-1:0]            unmatched;
    logic                    found;
    logic [ADDR_WIDTH-1:0]   pick;
    logic                    eval_now;

    assign unmatched = faulty_rows_mask & ~matched;
    assign eval_now  = !abort && (state == ROW_EVAL);

    // rd_data carries the weight zero-column mask during ROW_EVAL
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int f = 0; f < N; f++) begin
            if (!found && unmatched[f] && ((fmask[f] & ~rd_data) == '0)) begin
                found = 1'b1;
                pick  = ADDR_WIDTH'(f);
            end
        end
    end

    always_comb begin
        for (int f = 0; f < N - 1; f++)
            frm_nxt[f] = |fmask[f];
        frm_nxt[N-1] = |rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
                LOAD: begin
                    if (idx == LAST) state_nxt = LOAD_LAST;
                    else idx_nxt = idx + 1'b1;
                end
                LOAD_LAST: begin
                    state_nxt = ROW_RD;
                    idx_nxt   = '0;
                end
                ROW_RD:   state_nxt = ROW_EVAL;
                ROW_EVAL: state_nxt = ISSUE;
                ISSUE:    state_nxt = CHECK;
                CHECK: begin
                    if (idx == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ROW_RD;
                        idx_nxt   = idx + 1'b1;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en              <= 1'b0;
            rd_sel             <= 1'b0;
            rd_addr            <= '0;
            faulty_rows_mask   <= '0;
            table_init         <= 1'b0;
            match_success      <= 1'b0;
            match_failed       <= 1'b0;
            all_faulty_matched <= 1'b0;
            faulty_addr        <= '0;
            current_row_addr   <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            alloc_fail         <= 1'b0;
            fail_count         <= '0;
            fmask              <= '0;
            matched            <= '0;
        end else begin
            rd_en              <= (state_nxt == LOAD) || (state_nxt == ROW_RD);
            rd_sel             <= (state_nxt == ROW_RD);
            rd_addr            <= idx_nxt;
            table_init         <= !abort && (state == LOAD_LAST);
            busy               <= (state_nxt != IDLE);
            done               <= (state_nxt == DONE);
            match_success      <= eval_now && found;
            match_failed       <= eval_now && !found && (unmatched != '0);
            all_faulty_matched <= eval_now && !found && (unmatched == '0);
            if (!abort && state == IDLE && start) begin
                alloc_fail       <= 1'b0;
                fail_count       <= '0;
                matched          <= '0;
                faulty_rows_mask <= '0;
            end
            // read data lags the request by one cycle
            if (!abort && state == LOAD && idx != '0)
                fmask[idx - 1'b1] <= rd_data;
            if (!abort && state == LOAD_LAST) begin
                fmask[N-1]       <= rd_data;
                faulty_rows_mask <= frm_nxt;
            end
            if (eval_now) begin
                current_row_addr <= idx;
                if (found) begin
                    faulty_addr   <= pick;
                    matched[pick] <= 1'b1;
                end else if (unmatched != '0 && fail_count != FC_MAX) begin
                    fail_count <= fail_count + 1'b1;
                end
            end
            if (!abort && state == CHECK && allocation_failed_in)
                alloc_fail <= 1'b1;
        end
    end

endmodule

// File: doc/remap_alloc_ctrl.md
Name: remap_alloc_ctrl

Overview:
- Sequencer for fault-tolerant row remapping in the SYSTOLIC_SIZE×SYSTOLIC_SIZE array.
- Loads per-row faulty-column masks from the faulty-PE storage read port and publishes the faulty-row mask to the mapping table with an init pulse.
- Walks every weight row, matching it to a compatible unmatched faulty row where possible.
- Drives the mapping table's update interface with one event per row and collects allocation status.

Parameters:
SYSTOLIC_SIZE, 8, array dimension (rows = columns = N)
ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), row index width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin allocation pass; sampled only in IDLE
abort  input  1  return to IDLE next cycle from any state
rd_en  output  1  storage read request
rd_sel  output  1  0 = faulty-column mask, 1 = weight zero-column mask
rd_addr  output  ADDR_WIDTH  row index to read
rd_data  input  SYSTOLIC_SIZE  read data, valid exactly 1 cycle after rd_en
faulty_rows_mask  output  SYSTOLIC_SIZE  bit f = row f has ≥1 faulty PE
table_init  output  1  1-cycle mapping-table init pulse
match_success  output  1  1-cycle pulse: current row replaces faulty_addr
match_failed  output  1  1-cycle pulse: no compatible faulty row; unmatched faulty rows remain
all_faulty_matched  output  1  1-cycle pulse: no unmatched faulty rows remain
faulty_addr  output  ADDR_WIDTH  matched faulty row; valid only with match_success
current_row_addr  output  ADDR_WIDTH  row being allocated; valid with any event pulse
allocation_failed_in  input  1  registered failure flag from the mapping table
busy  output  1  high in every non-IDLE state
done  output  1  1-cycle pulse at pass completion
alloc_fail  output  1  sticky: any row reported allocation failure this pass
fail_count  output  ADDR_WIDTH+1  count of match_failed pulses this pass

Behaviour:
- Reset: all outputs 0, faulty_rows_mask = 0, internal mask registers 0, matched vector 0, state IDLE.
- All outputs are registered.
- States: IDLE, LOAD, LOAD_LAST, ROW_RD, ROW_EVAL, ISSUE, CHECK, DONE.
- IDLE:
  - start=1 at cycle 0 → LOAD at cycle 1.
  - Clears alloc_fail, fail_count, matched vector and faulty_rows_mask.
  - start is ignored in every other state.
- LOAD (cycles 1..N):
  - rd_en=1, rd_sel=0, rd_addr=idx, idx 0..N-1.
  - rd_data captured 1 cycle later into fmask[idx].
  - After idx N-1 → LOAD_LAST (cycle N+1): captures fmask[N-1] and sets faulty_rows_mask[f] = |fmask[f].
- Init pulse: table_init=1 in cycle N+2 only; faulty_rows_mask is stable from cycle N+2 until the next start.
- Per row r = 0..N-1, 4 cycles each:
  - ROW_RD (N+2+4r): rd_en=1, rd_sel=1, rd_addr=r.
  - ROW_EVAL (N+3+4r): capture zmask. A faulty row f is compatible when faulty_rows_mask[f] && !matched[f] && (fmask[f] & ~zmask)==0. Choose the lowest-index compatible f.
  - ISSUE (N+4+4r): exactly one pulse high; current_row_addr=r.
    - Compatible f found: match_success, faulty_addr=f, matched[f]←1.
    - Else, no unmatched faulty rows remain: all_faulty_matched.
    - Else: match_failed, fail_count+1.
  - CHECK (N+5+4r): if allocation_failed_in=1, alloc_fail←1. Then r+1 → ROW_RD, or after r=N-1 → DONE.
- DONE (cycle 5N+2): done=1 for 1 cycle → IDLE.
- Total latency from start sample to done pulse: 5N+2 cycles (42 for N=8).
- No faulty rows at all: every row issues all_faulty_matched.
- A faulty row may match itself when compatible.
- Each faulty row is matched at most once per pass.
- abort has priority over all transitions:
  - Next cycle: IDLE, rd_en and all pulses 0, busy 0, no done.
  - alloc_fail, fail_count and faulty_rows_mask hold their values.
- rst_n asserted mid-pass: immediate return to reset values.
- fail_count saturates at N.

Test Plan:
- N=8, all fmask=0 → table_init at cycle 10; 8 all_faulty_matched pulses at cycles 12,16,…,40; done at 42; fail_count=0.
- fmask[3]=8'h04, zmask[0]=8'h04 → row 0 issues match_success with faulty_addr=3; rows 1–7 issue all_faulty_matched; faulty_rows_mask=8'h08.
- fmask[2]=fmask[5]=8'h01, all zmask=0 → 8 match_failed pulses, fail_count=8, no match_success.
- fmask[1]=fmask[6]=8'h10, zmask[4]=8'hFF → row 4 matches faulty row 1; row 5 (zmask=8'h10) matches 6; other rows issue match_failed, or all_faulty_matched once both are matched.
- allocation_failed_in forced high at the CHECK cycle of row 2 → alloc_fail=1 stays set through done; cleared by the next start.
- abort at cycle 20 → IDLE at 21, busy=0, no further pulses, no done; a new start completes normally in 42 cycles.
